// File: rtl/sevenseg_scan_decoder.sv
// sevenseg_scan_decoder: recovers the digit values shown on a multiplexed
// 4-digit, 7-segment display by sampling its anode and segment lines.
// A digit is captured after SETTLE_CYCLES identical samples. Four captured
// digits form a frame, which is offered on a valid/ready output register.
// Optional build macro SEVENSEG_SCAN_ERRCNT_EN adds the err_count port, a
// saturating count of captures whose pattern was not recognised.
module sevenseg_scan_decoder #(
   parameter int unsigned SETTLE_CYCLES = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [3:0]  anodes,
   input  logic [6:0]  segments,
   input  logic        frame_ready,
   output logic        frame_valid,
   output logic [15:0] digits,
   output logic [3:0]  blank,
   output logic [3:0]  err,
   output logic        overrun
`ifdef SEVENSEG_SCAN_ERRCNT_EN
   ,
   output logic [7:0]  err_count
`endif
);

   typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

   localparam logic [7:0] SETTLE_N = SETTLE_CYCLES[7:0];

   state_t      state, state_nxt;
   logic [3:0]  ref_an, ref_an_nxt;
   logic [6:0]  ref_seg, ref_seg_nxt;
   logic [7:0]  stable_cnt, cnt_nxt;
   logic        capture;
   logic        idle_eval;
   logic        an_onehot;
   logic [1:0]  cap_idx;

   logic [3:0]  dec_nib;
   logic        dec_blank;
   logic        dec_err;

   logic [3:0]  mask, mask_nxt;
   logic [15:0] buf_digits;
   logic [3:0]  buf_blank;
   logic [3:0]  buf_err;
   logic        out_free;
   logic        mask_full;
   logic        transfer;
   logic        drop;
   logic        cap_write;

   // Qualify the anode lines and locate the selected digit slot
   always_comb begin
      an_onehot = (anodes != 4'b0000) && ((anodes & (anodes - 4'd1)) == 4'b0000);
      cap_idx   = 2'd0;
      case (anodes)
         4'b0010: cap_idx = 2'd1;
         4'b0100: cap_idx = 2'd2;
         4'b1000: cap_idx = 2'd3;
         default: cap_idx = 2'd0;
      endcase
   end

   // Decode the live segment pattern; it equals the reference whenever a capture fires
   always_comb begin
      dec_nib   = 4'hE;
      dec_blank = 1'b0;
      dec_err   = 1'b0;
      case (segments)
         7'b1111110: dec_nib = 4'h0;
         7'b0110000: dec_nib = 4'h1;
         7'b1101101: dec_nib = 4'h2;
         7'b1111001: dec_nib = 4'h3;
         7'b0110011: dec_nib = 4'h4;
         7'b1011011: dec_nib = 4'h5;
         7'b1011111: dec_nib = 4'h6;
         7'b1110000: dec_nib = 4'h7;
         7'b1111111: dec_nib = 4'h8;
         7'b1110011: dec_nib = 4'h9;
         7'b0000000: begin
            dec_nib   = 4'hF;
            dec_blank = 1'b1;
         end
         default: begin
            dec_nib = 4'hE;
            dec_err = 1'b1;
         end
      endcase
   end

   // Settle FSM: next state, reference sample, stability count and capture strobe
   always_comb begin
      state_nxt   = state;
      ref_an_nxt  = ref_an;
      ref_seg_nxt = ref_seg;
      cnt_nxt     = stable_cnt;
      capture     = 1'b0;
      idle_eval   = 1'b0;
      case (state)
         IDLE: idle_eval = 1'b1;
         SETTLE: begin
            if ((anodes != ref_an) || (segments != ref_seg)) begin
               // A mismatch is handled exactly like a fresh IDLE sample
               idle_eval = 1'b1;
            end else begin
               cnt_nxt = stable_cnt + 8'd1;
               if (cnt_nxt == SETTLE_N) begin
                  capture   = 1'b1;
                  state_nxt = HOLD;
               end
            end
         end
         HOLD: begin
            if (anodes != ref_an) idle_eval = 1'b1;
         end
         default: state_nxt = IDLE;
      endcase

      if (idle_eval) begin
         if (an_onehot) begin
            ref_an_nxt  = anodes;
            ref_seg_nxt = segments;
            cnt_nxt     = 8'd1;
            if (SETTLE_N == 8'd1) begin
               capture   = 1'b1;
               state_nxt = HOLD;
            end else begin
               state_nxt = SETTLE;
            end
         end else begin
            cnt_nxt   = '0;
            state_nxt = IDLE;
         end
      end
   end

   // Capture buffer control: transfer frees the mask before a same-cycle capture lands
   always_comb begin
      out_free  = !frame_valid || frame_ready;
      mask_full = (mask == 4'b1111);
      transfer  = mask_full && out_free;
      drop      = capture && mask_full && !out_free;
      cap_write = capture && !drop;
      mask_nxt  = transfer ? 4'b0000 : mask;
      if (cap_write) mask_nxt[cap_idx] = 1'b1;
   end

   // FSM state, reference sample and stability counter registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         ref_an     <= '0;
         ref_seg    <= '0;
         stable_cnt <= '0;
      end else begin
         state      <= state_nxt;
         ref_an     <= ref_an_nxt;
         ref_seg    <= ref_seg_nxt;
         stable_cnt <= cnt_nxt;
      end
   end

   // Capture buffer slots and their fill mask
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mask       <= '0;
         buf_digits <= '0;
         buf_blank  <= '0;
         buf_err    <= '0;
      end else begin
         mask <= mask_nxt;
         if (cap_write) begin
            buf_digits[{cap_idx, 2'b00} +: 4] <= dec_nib;
            buf_blank[cap_idx]                <= dec_blank;
            buf_err[cap_idx]                  <= dec_err;
         end
      end
   end

   // Output frame register with valid/ready handshake and overrun pulse
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         frame_valid <= 1'b0;
         digits      <= '0;
         blank       <= '0;
         err         <= '0;
         overrun     <= 1'b0;
      end else begin
         overrun <= drop;
         if (transfer) begin
            digits      <= buf_digits;
            blank       <= buf_blank;
            err         <= buf_err;
            frame_valid <= 1'b1;
         end else if (frame_valid && frame_ready) begin
            frame_valid <= 1'b0;
         end
      end
   end

`ifdef SEVENSEG_SCAN_ERRCNT_EN
   // Saturating count of unrecognised captures, cleared only by reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         err_count <= '0;
      end else if (capture && dec_err && (err_count != 8'hFF)) begin
         err_count <= err_count + 8'd1;
      end
   end
`endif

endmodule

// File: tb/tb_sevenseg_scan_decoder.sv
// Bench for sevenseg_scan_decoder: directed scans plus random scanning,
// checked every cycle against a sample-history reference model.
module tb_sevenseg_scan_decoder;

   localparam int unsigned N = 4;

   localparam logic [6:0] P0   = 7'b1111110;
   localparam logic [6:0] P1   = 7'b0110000;
   localparam logic [6:0] P2   = 7'b1101101;
   localparam logic [6:0] P3   = 7'b1111001;
   localparam logic [6:0] P4   = 7'b0110011;
   localparam logic [6:0] P5   = 7'b1011011;
   localparam logic [6:0] P6   = 7'b1011111;
   localparam logic [6:0] P7   = 7'b1110000;
   localparam logic [6:0] P8   = 7'b1111111;
   localparam logic [6:0] P9   = 7'b1110011;
   localparam logic [6:0] ERRP = 7'b1000001;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  anodes;
   logic [6:0]  segments;
   logic        frame_ready;
   logic        frame_valid;
   logic [15:0] digits;
   logic [3:0]  blank;
   logic [3:0]  err;
   logic        overrun;
`ifdef SEVENSEG_SCAN_ERRCNT_EN
   logic [7:0]  err_count;
`endif

   always #5 clk = ~clk;

   sevenseg_scan_decoder #(.SETTLE_CYCLES(N)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .anodes      (anodes),
      .segments    (segments),
      .frame_ready (frame_ready),
      .frame_valid (frame_valid),
      .digits      (digits),
      .blank       (blank),
      .err         (err),
      .overrun     (overrun)
`ifdef SEVENSEG_SCAN_ERRCNT_EN
      ,
      .err_count   (err_count)
`endif
   );

   int total = 0;
   int bad   = 0;
   int ovr_seen = 0;

   logic [6:0] pat_tab [10] = '{P0, P1, P2, P3, P4, P5, P6, P7, P8, P9};

   // reference model state
   logic [10:0] hist[$];
   bit          dwell_cap;
   logic [3:0]  m_nib [4];
   logic        m_bl  [4];
   logic        m_er  [4];
   logic [3:0]  m_mask;
   logic        m_fv;
   logic [15:0] m_digits;
   logic [3:0]  m_blank;
   logic [3:0]  m_err;
   logic        m_ovr;
   int          m_errcnt;

   function automatic void decode(input logic [6:0] sg, output logic [3:0] nib,
                                  output logic bl, output logic er);
      nib = 4'hE;
      bl  = 1'b0;
      er  = 1'b1;
      if (sg == 7'b0000000) begin
         nib = 4'hF;
         bl  = 1'b1;
         er  = 1'b0;
      end else begin
         for (int i = 0; i < 10; i++) begin
            if (pat_tab[i] == sg) begin
               nib = 4'(i);
               er  = 1'b0;
            end
         end
      end
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // A digit is captured once the last N samples are identical with a single
   // anode lit, and only once per uninterrupted anode dwell.
   task automatic model_edge();
      logic [10:0] last;
      logic [10:0] cur;
      bit          cap;
      bit          full;
      bit          free;
      bit          drp;
      int          idx;
      logic [3:0]  nib;
      logic        bl;
      logic        er;
      if (!rst_n) begin
         hist.delete();
         dwell_cap = 0;
         m_mask = '0;
         for (int i = 0; i < 4; i++) begin
            m_nib[i] = '0;
            m_bl[i]  = 1'b0;
            m_er[i]  = 1'b0;
         end
         m_fv = 1'b0;
         m_digits = '0;
         m_blank = '0;
         m_err = '0;
         m_ovr = 1'b0;
         m_errcnt = 0;
         return;
      end
      cur = {anodes, segments};
      if (hist.size() > 0) begin
         last = hist[hist.size() - 1];
         if (last[10:7] != anodes) dwell_cap = 0;
      end
      hist.push_back(cur);
      if (hist.size() > N) void'(hist.pop_front());
      cap = (hist.size() == N) && ($countones(anodes) == 1) && !dwell_cap;
      for (int i = 0; i < hist.size(); i++) if (hist[i] != cur) cap = 0;
      if (cap) dwell_cap = 1;
      idx = 0;
      for (int i = 0; i < 4; i++) if (anodes[i]) idx = i;
      decode(segments, nib, bl, er);
      full = (m_mask == 4'b1111);
      free = !m_fv || frame_ready;
      drp  = cap && full && !free;
      if (full && free) begin
         m_digits = {m_nib[3], m_nib[2], m_nib[1], m_nib[0]};
         m_blank  = {m_bl[3], m_bl[2], m_bl[1], m_bl[0]};
         m_err    = {m_er[3], m_er[2], m_er[1], m_er[0]};
         m_fv     = 1'b1;
         m_mask   = '0;
      end else if (m_fv && frame_ready) begin
         m_fv = 1'b0;
      end
      m_ovr = drp;
      if (cap && !drp) begin
         m_nib[idx]  = nib;
         m_bl[idx]   = bl;
         m_er[idx]   = er;
         m_mask[idx] = 1'b1;
      end
      if (cap && er && m_errcnt < 255) m_errcnt++;
   endtask

   task automatic check_outputs();
      chk("frame_valid", 32'(frame_valid), 32'(m_fv));
      chk("digits", 32'(digits), 32'(m_digits));
      chk("blank", 32'(blank), 32'(m_blank));
      chk("err", 32'(err), 32'(m_err));
      chk("overrun", 32'(overrun), 32'(m_ovr));
`ifdef SEVENSEG_SCAN_ERRCNT_EN
      chk("err_count", 32'(err_count), 32'(m_errcnt));
`endif
      if (overrun === 1'b1) ovr_seen++;
   endtask

   task automatic step(input logic [3:0] an, input logic [6:0] sg, input logic rdy, input logic rn);
      anodes      = an;
      segments    = sg;
      frame_ready = rdy;
      rst_n       = rn;
      @(posedge clk);
      model_edge();
      #1;
      check_outputs();
   endtask

   task automatic dwell(input logic [3:0] an, input logic [6:0] sg, input int len, input logic rdy);
      for (int i = 0; i < len; i++) step(an, sg, rdy, 1'b1);
   endtask

   initial begin
      logic [3:0] ran;
      logic [6:0] rsg;
      int         r;
      int         len;

      rst_n = 1'b0;
      anodes = '0;
      segments = '0;
      frame_ready = 1'b0;

      // reset
      repeat (3) step(4'b0000, 7'b0000000, 1'b0, 1'b0);
      chk("rst_fv", 32'(frame_valid), 32'd0);
      chk("rst_digits", 32'(digits), 32'h0);
      chk("rst_overrun", 32'(overrun), 32'd0);

      // basic scan 1,2,3,4 with latency check on the last digit
      dwell(4'b0001, P1, 6, 1'b0);
      dwell(4'b0010, P2, 6, 1'b0);
      dwell(4'b0100, P3, 6, 1'b0);
      for (int i = 0; i < 6; i++) begin
         step(4'b1000, P4, 1'b0, 1'b1);
         if (i == 3) chk("lat_before", 32'(frame_valid), 32'd0);
         if (i == 4) chk("lat_rise", 32'(frame_valid), 32'd1);
      end
      chk("scan_digits", 32'(digits), 32'h4321);
      chk("scan_err", 32'(err), 32'h0);
      chk("scan_blank", 32'(blank), 32'h0);
      step(4'b0000, 7'b0000000, 1'b1, 1'b1);
      chk("hs_drop", 32'(frame_valid), 32'd0);

      // glitch on cycle 3 of a dwell, then a 3-cycle dwell that must not capture
      step(4'b0001, P1, 1'b0, 1'b1);
      step(4'b0001, P1, 1'b0, 1'b1);
      step(4'b0001, P8, 1'b0, 1'b1);
      dwell(4'b0001, P5, 4, 1'b0);
      dwell(4'b0010, P2, 3, 1'b0);
      dwell(4'b0100, P6, 6, 1'b0);
      dwell(4'b1000, P7, 6, 1'b0);
      chk("short_dwell_no_frame", 32'(frame_valid), 32'd0);
      dwell(4'b0010, P9, 6, 1'b0);
      step(4'b0000, 7'b0000000, 1'b0, 1'b1);
      chk("glitch_digits", 32'(digits), 32'h7695);
      step(4'b0000, 7'b0000000, 1'b1, 1'b1);

      // non-one-hot anodes, unrecognised and blank patterns
      dwell(4'b0011, P8, 10, 1'b0);
      dwell(4'b0001, P0, 6, 1'b0);
      dwell(4'b0010, P7, 6, 1'b0);
      dwell(4'b0100, ERRP, 6, 1'b0);
      dwell(4'b1000, 7'b0000000, 6, 1'b0);
      step(4'b0000, 7'b0000000, 1'b0, 1'b1);
      chk("mix_digits", 32'(digits), 32'hFE70);
      chk("mix_err", 32'(err), 32'b0100);
      chk("mix_blank", 32'(blank), 32'b1000);
      step(4'b0000, 7'b0000000, 1'b1, 1'b1);

      // back-pressure: two full scans held, third scan dropped
      dwell(4'b0001, P5, 6, 1'b0);
      dwell(4'b0010, P6, 6, 1'b0);
      dwell(4'b0100, P8, 6, 1'b0);
      dwell(4'b1000, P9, 6, 1'b0);
      dwell(4'b0001, P3, 6, 1'b0);
      dwell(4'b0010, P2, 6, 1'b0);
      dwell(4'b0100, P1, 6, 1'b0);
      dwell(4'b1000, P0, 6, 1'b0);
      ovr_seen = 0;
      dwell(4'b0001, P7, 6, 1'b0);
      dwell(4'b0010, P7, 6, 1'b0);
      dwell(4'b0100, P7, 6, 1'b0);
      dwell(4'b1000, P7, 6, 1'b0);
      chk("ovr_pulses", 32'(ovr_seen), 32'd4);
      chk("held_digits", 32'(digits), 32'h9865);
      chk("held_fv", 32'(frame_valid), 32'd1);
      step(4'b0000, 7'b0000000, 1'b1, 1'b1);
      chk("reload_fv", 32'(frame_valid), 32'd1);
      chk("reload_digits", 32'(digits), 32'h0123);

      // reset mid-SETTLE with three digits captured
      step(4'b0000, 7'b0000000, 1'b1, 1'b1);
      dwell(4'b0001, P0, 6, 1'b1);
      dwell(4'b0010, P1, 6, 1'b1);
      dwell(4'b0100, P2, 6, 1'b1);
      dwell(4'b1000, P3, 2, 1'b1);
      step(4'b1000, P3, 1'b1, 1'b0);
      chk("mid_rst_fv", 32'(frame_valid), 32'd0);
      chk("mid_rst_digits", 32'(digits), 32'h0);
      chk("mid_rst_err", 32'(err), 32'h0);
      dwell(4'b1000, P3, 6, 1'b0);
      chk("mid_rst_no_frame", 32'(frame_valid), 32'd0);

      // random scanning with glitches, random ready and rare resets
      for (int k = 0; k < 120; k++) begin
         r = int'($urandom_range(0, 9));
         if (r < 8) ran = 4'b0001 << $urandom_range(0, 3);
         else       ran = 4'($urandom);
         r = int'($urandom_range(0, 11));
         if (r < 10)      rsg = pat_tab[r];
         else if (r == 10) rsg = 7'b0000000;
         else              rsg = 7'($urandom);
         len = int'($urandom_range(1, 7));
         for (int j = 0; j < len; j++) begin
            step(ran, ($urandom_range(0, 7) == 0) ? 7'($urandom) : rsg,
                 1'($urandom_range(0, 1)), ($urandom_range(0, 99) != 0));
         end
      end

`ifdef SEVENSEG_SCAN_ERRCNT_EN
      // error-count saturation
      step(4'b0000, 7'b0000000, 1'b1, 1'b0);
      for (int i = 0; i < 300; i++) begin
         ran = 4'b0001 << (i % 4);
         dwell(ran, ERRP, 5, 1'b1);
      end
      chk("errcnt_sat", 32'(err_count), 32'hFF);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
